// File: rtl/plane_spawner.sv
// Plane slot table: on each move tick, shifts active planes left, retires off-screen planes,
// spawns new ones up to the allowed count, then streams the active planes to the draw logic.
module plane_spawner #(
    parameter int unsigned MAX_PLANES = 10,
    parameter int unsigned X_MAX      = 160,
    parameter int unsigned Y_MAX      = 120,
    parameter int unsigned TICK_DIV   = 50,
    parameter int unsigned SPAWN_GAP  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] plane_amount,
    input  logic [1:0] flying_rate,
    output logic       plane_valid,
    output logic [7:0] plane_x,
    output logic [6:0] plane_y,
    output logic [3:0] plane_id,
    output logic       frame_done,
    output logic [3:0] active_count
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned GAP_W = $clog2(SPAWN_GAP) + 1;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_SPAWN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        tick_cnt;
    logic [GAP_W-1:0]        gap;
    logic                    pending;
    logic [7:0]              lfsr;
    logic [IDX_W-1:0]        idx;
    logic [MAX_PLANES-1:0]   active;
    logic [7:0]              slot_x [MAX_PLANES];
    logic [6:0]              slot_y [MAX_PLANES];

    logic                    tick;
    logic [IDX_W-1:0]        pop;
    logic                    free_found;
    logic [IDX_W-1:0]        free_idx;
    logic [3:0]              amt;
    logic [7:0]              lfsr_next;
    logic [6:0]              spawn_y;
    logic [2:0]              step;

    // Tick strobe, speed step and spawn parameters derived from the current inputs.
    always_comb begin
        tick      = enable && (tick_cnt == CNT_W'(TICK_DIV - 1));
        step      = {1'b0, flying_rate} + 3'd1;
        amt       = (plane_amount > 4'(MAX_PLANES)) ? 4'(MAX_PLANES) : plane_amount;
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        spawn_y   = (lfsr_next[6:0] < 7'(Y_MAX)) ? lfsr_next[6:0]
                                                 : lfsr_next[6:0] - 7'(Y_MAX);
    end

    // Occupancy count and lowest-index free slot.
    always_comb begin
        pop        = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(MAX_PLANES); i++) begin
            if (active[i]) begin
                pop = pop + IDX_W'(1);
            end else if (!free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            tick_cnt     <= '0;
            gap          <= '0;
            pending      <= 1'b0;
            lfsr         <= 8'hA5;
            idx          <= '0;
            active       <= '0;
            plane_valid  <= 1'b0;
            plane_x      <= '0;
            plane_y      <= '0;
            plane_id     <= '0;
            frame_done   <= 1'b0;
            active_count <= '0;
            for (int i = 0; i < int'(MAX_PLANES); i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
            end
        end else begin
            if (enable) begin
                tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            end

            plane_valid <= 1'b0;
            plane_x     <= '0;
            plane_y     <= '0;
            plane_id    <= '0;
            frame_done  <= 1'b0;

            // A tick arriving mid-walk is remembered once; further ones are dropped.
            if (state != S_IDLE && tick) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (tick || pending) begin
                        state   <= S_MOVE;
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                S_MOVE: begin
                    if (active[idx]) begin
                        if (slot_x[idx] >= 8'(step)) begin
                            slot_x[idx] <= slot_x[idx] - 8'(step);
                        end else begin
                            active[idx] <= 1'b0;
                            slot_x[idx] <= '0;
                            slot_y[idx] <= '0;
                        end
                    end
                    if (idx == IDX_W'(MAX_PLANES - 1)) begin
                        state <= S_SPAWN;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_SPAWN: begin
                    lfsr <= lfsr_next;
                    if (pop < amt && gap == '0 && free_found) begin
                        active[free_idx] <= 1'b1;
                        slot_x[free_idx] <= 8'(X_MAX - 1);
                        slot_y[free_idx] <= spawn_y;
                        gap              <= GAP_W'(SPAWN_GAP - 1);
                        active_count     <= pop + IDX_W'(1);
                    end else begin
                        if (gap != '0) begin
                            gap <= gap - GAP_W'(1);
                        end
                        active_count <= pop;
                    end
                    state <= S_EMIT;
                    idx   <= '0;
                end
                S_EMIT: begin
                    if (active[idx]) begin
                        plane_valid <= 1'b1;
                        plane_x     <= slot_x[idx];
                        plane_y     <= slot_y[idx];
                        plane_id    <= idx;
                    end
                    if (idx == IDX_W'(MAX_PLANES - 1)) begin
                        state <= S_DONE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_plane_spawner.sv
// Self-checking bench for plane_spawner: a walk-level model predicts each walk's emissions
// and final active_count when a tick occurs; a monitor pops and compares them as the DUT emits.
module tb_plane_spawner;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] plane_amount;
    logic [1:0] flying_rate;
    logic       plane_valid;
    logic [7:0] plane_x;
    logic [6:0] plane_y;
    logic [3:0] plane_id;
    logic       frame_done;
    logic [3:0] active_count;

    plane_spawner dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .plane_amount (plane_amount),
        .flying_rate  (flying_rate),
        .plane_valid  (plane_valid),
        .plane_x      (plane_x),
        .plane_y      (plane_y),
        .plane_id     (plane_id),
        .frame_done   (frame_done),
        .active_count (active_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       done;
        logic [3:0] id;
        logic [7:0] x;
        logic [6:0] y;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bit         m_act [10];
    int         m_x   [10];
    int         m_y   [10];
    int         m_gap;
    logic [7:0] m_lfsr;
    int         m_cnt;
    bit         tick_seen;
    int         max_cnt;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_act[i] = 1'b0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
        m_gap  = 0;
        m_lfsr = 8'hA5;
        m_cnt  = 0;
        sb.delete();
    endtask

    // One whole walk at transaction level: move, spawn, then the expected output stream.
    task automatic model_walk();
        int   step;
        int   amt;
        int   n;
        int   fs;
        int   l;
        exp_t e;
        step = int'(flying_rate) + 1;
        amt  = (plane_amount > 4'd10) ? 10 : int'(plane_amount);
        for (int i = 0; i < 10; i++) begin
            if (m_act[i]) begin
                if (m_x[i] >= step) m_x[i] = m_x[i] - step;
                else m_act[i] = 1'b0;
            end
        end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        n  = 0;
        fs = -1;
        for (int i = 0; i < 10; i++) begin
            if (m_act[i]) n++;
            else if (fs < 0) fs = i;
        end
        if (n < amt && m_gap == 0) begin
            l = int'(m_lfsr[6:0]);
            m_act[fs] = 1'b1;
            m_x[fs]   = 159;
            m_y[fs]   = (l < 120) ? l : l - 120;
            m_gap     = 3;
            n++;
        end else if (m_gap > 0) begin
            m_gap--;
        end
        for (int i = 0; i < 10; i++) begin
            if (m_act[i]) begin
                e      = '0;
                e.id   = 4'(i);
                e.x    = 8'(m_x[i]);
                e.y    = 7'(m_y[i]);
                sb.push_back(e);
            end
        end
        e      = '0;
        e.done = 1'b1;
        e.cnt  = 4'(n);
        sb.push_back(e);
    endtask

    // Stimulus-side tick tracking: a walk is predicted every TICK_DIV enabled cycles.
    always @(posedge clk) begin
        if (reset) begin
            model_reset();
        end else if (enable) begin
            if (m_cnt == 49) begin
                m_cnt = 0;
                model_walk();
                tick_seen = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset && (plane_valid || frame_done)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                if (e.done) begin
                    check("kind_done", {30'd0, plane_valid, frame_done}, 1);
                    check("active_count", active_count, e.cnt);
                end else begin
                    check("kind_plane", {30'd0, plane_valid, frame_done}, 2);
                    check("plane_id", plane_id, e.id);
                    check("plane_x", plane_x, e.x);
                    check("plane_y", plane_y, e.y);
                end
            end
        end
    end

    task automatic wait_frame();
        int n;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (frame_done) break;
        end
        if (n >= 200) check("frame_timeout", 0, 1);
        if (active_count > max_cnt) max_cnt = active_count;
    endtask

    task automatic run_walks(input int k);
        for (int i = 0; i < k; i++) wait_frame();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, plane_valid, 0);
        check({tag, "_x"}, plane_x, 0);
        check({tag, "_y"}, plane_y, 0);
        check({tag, "_id"}, plane_id, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_count"}, active_count, 0);
    endtask

    // Counts cycles from enable rising to the first emission and checks the first plane.
    task automatic first_emission(input string tag);
        int n;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (plane_valid) break;
        end
        check({tag, "_latency"}, n, 62);
        check({tag, "_id"}, plane_id, 0);
        check({tag, "_x"}, plane_x, 159);
        check({tag, "_y"}, plane_y, 74);
    endtask

    initial begin
        int n;
        tick_seen    = 1'b0;
        max_cnt      = 0;
        reset        = 1'b1;
        enable       = 1'b0;
        plane_amount = 4'd0;
        flying_rate  = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");

        @(negedge clk);
        reset        = 1'b0;
        enable       = 1'b1;
        plane_amount = 4'd1;
        flying_rate  = 2'd0;
        first_emission("first");
        wait_frame();
        check("count_after_first", active_count, 1);
        run_walks(4);

        plane_amount = 4'd3;
        run_walks(12);
        check("count_three", active_count, 3);

        flying_rate = 2'd3;
        run_walks(45);

        plane_amount = 4'd15;
        flying_rate  = 2'd0;
        max_cnt      = 0;
        run_walks(70);
        check("count_saturated", max_cnt, 10);

        plane_amount = 4'd0;
        run_walks(5);

        // Drop enable during the emission phase of a walk.
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (plane_valid) break;
        end
        check("emit_before_disable", n < 200 ? 1 : 0, 1);
        enable = 1'b0;
        wait_frame();
        repeat (150) @(posedge clk);
        #1;
        check("queue_empty_disabled", sb.size(), 0);

        // Re-enable, then reset in the middle of the move phase.
        enable    = 1'b1;
        tick_seen = 1'b0;
        n = 0;
        while (n < 200 && !tick_seen) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tick_after_reenable", int'(tick_seen), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        check_zero_outputs("midmove_reset");
        @(negedge clk);
        reset        = 1'b0;
        enable       = 1'b1;
        plane_amount = 4'd1;
        flying_rate  = 2'd0;
        first_emission("post_reset");
        wait_frame();
        check("post_reset_count", active_count, 1);
        check("queue_empty_end", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
